montgomery_exp_ctrl: RTL
========================

// Module: montgomery_exp_ctrl
// PURPOSE
//  Sequencer for a modular exponentiation built on the shared `montgomery` multiplier.
//  Runs left-to-right square-and-multiply over an E_LEN-bit exponent and issues one
//  multiplication at a time. It ends with a conversion multiply by 1, so result = x^e mod m
//  in the normal domain. Sits between the top-level/AXI control and the `montgomery` instance.
// PARAMETERS
//  WIDTH   1024  operand / modulus width in bits
//  ELEN_W  11    width of exponent-length field (e_len range 0..WIDTH)
// PORTS
//  clk          in   1          rising-edge clock
//  resetn       in   1          asynchronous active-low reset
//  start        in   1          request; sampled only in IDLE
//  in_xm        in   WIDTH      base in Montgomery domain (x*R mod m), R=2^WIDTH
//  in_rm        in   WIDTH      R mod m (Montgomery one)
//  in_m         in   WIDTH      odd modulus
//  in_e         in   WIDTH      exponent; bits [e_len-1:0] used
//  in_e_len     in   ELEN_W     number of exponent bits processed
//  mont_start   out  1          one-cycle start pulse to multiplier
//  mont_a       out  WIDTH      multiplier operand a (registered, stable while busy)
//  mont_b       out  WIDTH      multiplier operand b (registered, stable while busy)
//  mont_m       out  WIDTH      multiplier modulus (latched in_m)
//  mont_result  in   WIDTH      multiplier result, valid when mont_done=1
//  mont_done    in   1          multiplier completion pulse
//  result       out  WIDTH      x^e mod m; held until the next accepted start
//  done         out  1          one-cycle pulse, result valid in the same cycle
//  busy         out  1          high from the cycle after start is accepted until done
// BEHAVIOUR
//  Reset: all outputs and registers 0; state=IDLE. Reset mid-operation aborts it at once;
//   no mont_start is issued afterwards and the multiplier result is ignored.
//  States: IDLE, SQ_GO, SQ_WAIT, MUL_GO, MUL_WAIT, CV_GO, CV_WAIT, FIN.
//  IDLE & start: latch xm, m, e, e_len; acc<=rm; idx<=e_len-1.
//   Next state is SQ_GO if e_len!=0, else CV_GO.
//  *_GO: mont_start=1 for exactly one cycle; unconditionally -> matching *_WAIT.
//   Operands: SQ a=b=acc; MUL a=acc, b=xm; CV a=acc, b=1.
//  *_WAIT: hold until mont_done; that cycle acc<=mont_result, then:
//   SQ_WAIT  -> MUL_GO if e[idx]=1, else (idx==0 ? CV_GO : idx--, SQ_GO)
//   MUL_WAIT -> idx==0 ? CV_GO : (idx--, SQ_GO)
//   CV_WAIT  -> FIN with result<=mont_result.
//  FIN: done=1, busy=0 for one cycle -> IDLE. A start in FIN is ignored.
//  start while busy: ignored. mont_done outside *_WAIT: ignored.
//  Multiplications per run N = e_len + popcount(e[e_len-1:0]) + 1.
//  Timing: start accepted in cycle 0; first mont_start in cycle 1.
//   The next mont_start is exactly 1 cycle after each mont_done.
//   With multiplier latency L (mont_done L cycles after mont_start), done is in cycle 1+N*(L+1).
//  in_e_len > WIDTH: out of contract, behaviour undefined.
//  The whole block has no arithmetic other than the idx decrement.
//  Inputs after acceptance do not affect the run.
// TESTING
//  Behavioural mont model with programmable latency L computes a*b*R^-1 mod m; all cases also
//  run end-to-end against the real `montgomery`.
//  1) m=13, rm=3, xm=6 (x=2), e=5, e_len=3, L=4 -> result=6.
//     Exactly 6 mont_start pulses; done in cycle 31.
//  2) m=13, rm=3, xm=6, e_len=0 -> result=1, 1 mont_start, done in cycle 1+(L+1).
//  3) m=13, rm=3, xm=6, e=8'h80, e_len=8 -> result=9 (2^128 mod 13), 10 mont_start pulses.
//  4) start held high through run 1 -> a single run, one done pulse, no extra mont_start.
//     Stray mont_done injected in SQ_GO -> ignored.
//  5) resetn low during MUL_WAIT -> busy=0, done=0, mont_start=0, result=0.
//     Then rerun case 1 -> result=6.
//  6) 1024-bit random m/x/e from the test vector generator, e_len=1024, real multiplier ->
//     result matches the Python golden value.

Source files
------------

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery multiplier.
// Issues one multiplication at a time and finishes with a multiply by 1, so the
// result is x^e mod m in the normal domain.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start; operands latched on acceptance
// S_SQ_GO    | mont_start pulse for acc*acc
// S_SQ_WAIT  | waiting for the square result
// S_MUL_GO   | mont_start pulse for acc*xm (current exponent bit is 1)
// S_MUL_WAIT | waiting for the multiply result
// S_CV_GO    | mont_start pulse for acc*1 (leave the Montgomery domain)
// S_CV_WAIT  | waiting for the conversion result
// S_FIN      | done pulse, result valid
module montgomery_exp_ctrl #(
  parameter int WIDTH  = 1024,
  parameter int ELEN_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_xm,
  input  logic [WIDTH-1:0]  in_rm,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_e_len,
  output logic              mont_start,
  output logic [WIDTH-1:0]  mont_a,
  output logic [WIDTH-1:0]  mont_b,
  output logic [WIDTH-1:0]  mont_m,
  input  logic [WIDTH-1:0]  mont_result,
  input  logic              mont_done,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ_GO,
    S_SQ_WAIT,
    S_MUL_GO,
    S_MUL_WAIT,
    S_CV_GO,
    S_CV_WAIT,
    S_FIN
  } state_e;

  localparam logic [WIDTH-1:0]  ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ELEN_W-1:0] ONE_E = {{(ELEN_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [ELEN_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  xm_q;
  logic [WIDTH-1:0]  e_q;
  logic [WIDTH-1:0]  mont_a_q, mont_b_q, mont_m_q;
  logic [WIDTH-1:0]  result_q;
  logic              mont_start_q, done_q, busy_q;

  logic e_bit;
  logic idx_zero;

  // Mask-and-reduce rather than a variable index keeps idx wider than log2(WIDTH) legal.
  assign e_bit    = |(e_q & (ONE_W << idx_q));
  assign idx_zero = (idx_q == '0);

  // Next-state, accumulator and bit-index decisions.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = in_rm;
          idx_d   = in_e_len - ONE_E;
          state_d = (in_e_len != '0) ? S_SQ_GO : S_CV_GO;
        end
      end
      S_SQ_GO:  state_d = S_SQ_WAIT;
      S_MUL_GO: state_d = S_MUL_WAIT;
      S_CV_GO:  state_d = S_CV_WAIT;
      S_SQ_WAIT: begin
        if (mont_done) begin
          acc_d = mont_result;
          if (e_bit) begin
            state_d = S_MUL_GO;
          end else if (idx_zero) begin
            state_d = S_CV_GO;
          end else begin
            idx_d   = idx_q - ONE_E;
            state_d = S_SQ_GO;
          end
        end
      end
      S_MUL_WAIT: begin
        if (mont_done) begin
          acc_d = mont_result;
          if (idx_zero) begin
            state_d = S_CV_GO;
          end else begin
            idx_d   = idx_q - ONE_E;
            state_d = S_SQ_GO;
          end
        end
      end
      S_CV_WAIT: begin
        if (mont_done) begin
          acc_d   = mont_result;
          state_d = S_FIN;
        end
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register plus registered outputs; operands are loaded on entry to each *_GO
  // state so they are already valid in the cycle mont_start is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      xm_q         <= '0;
      e_q          <= '0;
      mont_a_q     <= '0;
      mont_b_q     <= '0;
      mont_m_q     <= '0;
      result_q     <= '0;
      mont_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;

      if (state_q == S_IDLE && start) begin
        xm_q     <= in_xm;
        e_q      <= in_e;
        mont_m_q <= in_m;
      end

      mont_start_q <= 1'b0;
      unique case (state_d)
        S_SQ_GO: begin
          mont_start_q <= 1'b1;
          mont_a_q     <= acc_d;
          mont_b_q     <= acc_d;
        end
        S_MUL_GO: begin
          mont_start_q <= 1'b1;
          mont_a_q     <= acc_d;
          mont_b_q     <= xm_q;
        end
        S_CV_GO: begin
          mont_start_q <= 1'b1;
          mont_a_q     <= acc_d;
          mont_b_q     <= ONE_W;
        end
        default: ;
      endcase

      if (state_q == S_CV_WAIT && mont_done) begin
        result_q <= mont_result;
      end

      done_q <= (state_d == S_FIN);
      busy_q <= (state_d != S_IDLE) && (state_d != S_FIN);
    end
  end

  assign mont_start = mont_start_q;
  assign mont_a     = mont_a_q;
  assign mont_b     = mont_b_q;
  assign mont_m     = mont_m_q;
  assign result     = result_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule
